// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared opcodes, flag indices and flag helpers for the execute stage
package execute_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SHL   = 4'b0100;
    localparam logic [3:0] ALU_SHR   = 4'b0101;
    localparam logic [3:0] ALU_NOT   = 4'b0110;
    localparam logic [3:0] ALU_PASS2 = 4'b0111;
    localparam logic [3:0] ALU_INC   = 4'b1000;
    localparam logic [3:0] ALU_DEC   = 4'b1001;
    localparam logic [3:0] ALU_PASS1 = 4'b1010;
    localparam logic [3:0] ALU_SETC  = 4'b1011;
    localparam logic [3:0] ALU_CLRC  = 4'b1100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Packs the four flags into the {V,C,N,Z} status layout.
    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result and next flags from op, operands and current flags
module alu_core
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       k,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;
    logic [WIDTH:0] shl_w;
    logic [WIDTH:0] shr_w;

    // One extra bit on each side so carry/borrow and the last shifted-out bit fall out directly.
    assign sum_w  = {1'b0, b} + {1'b0, a};
    assign diff_w = {1'b0, b} - {1'b0, a};
    assign inc_w  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
    assign shl_w  = {1'b0, a} << k;
    assign shr_w  = {a, 1'b0} >> k;

    logic c_new;
    logic v_new;
    logic zn_upd;

    always_comb begin
        result = '0;
        c_new  = flags_in[FLAG_C];
        v_new  = flags_in[FLAG_V];
        zn_upd = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum_w[WIDTH-1:0];
                c_new  = sum_w[WIDTH];
                v_new  = (a[MSB] == b[MSB]) && (sum_w[MSB] != b[MSB]);
                zn_upd = 1'b1;
            end
            ALU_SUB: begin
                result = diff_w[WIDTH-1:0];
                c_new  = diff_w[WIDTH];
                v_new  = (a[MSB] != b[MSB]) && (diff_w[MSB] != b[MSB]);
                zn_upd = 1'b1;
            end
            ALU_AND: begin
                result = a & b;
                zn_upd = 1'b1;
            end
            ALU_OR: begin
                result = a | b;
                zn_upd = 1'b1;
            end
            ALU_SHL: begin
                result = a;
                if (k != 4'd0) begin
                    result = shl_w[WIDTH-1:0];
                    c_new  = shl_w[WIDTH];
                end
                zn_upd = 1'b1;
            end
            ALU_SHR: begin
                result = a;
                if (k != 4'd0) begin
                    result = shr_w[WIDTH:1];
                    c_new  = shr_w[0];
                end
                zn_upd = 1'b1;
            end
            ALU_NOT: begin
                result = ~a;
                zn_upd = 1'b1;
            end
            ALU_PASS2: result = b;
            ALU_INC: begin
                result = inc_w[WIDTH-1:0];
                c_new  = inc_w[WIDTH];
                v_new  = ~a[MSB] & inc_w[MSB];
                zn_upd = 1'b1;
            end
            ALU_DEC: begin
                result = dec_w[WIDTH-1:0];
                c_new  = dec_w[WIDTH];
                v_new  = a[MSB] & ~dec_w[MSB];
                zn_upd = 1'b1;
            end
            ALU_PASS1: result = a;
            ALU_SETC: begin
                result = a;
                c_new  = 1'b1;
            end
            ALU_CLRC: begin
                result = a;
                c_new  = 1'b0;
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags_out = pack_flags(v_new, c_new,
                               zn_upd ? result[MSB]  : flags_in[FLAG_N],
                               zn_upd ? (result == '0) : flags_in[FLAG_Z]);
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: ALU plus the architectural status register
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] RegSrc,
    input  logic [WIDTH-1:0] RegDst,
    input  logic [WIDTH-1:0] immediate,
    output logic [3:0]       newStatus,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       status
);

    logic [3:0] status_q;
    logic [3:0] status_d;
    logic       unused_imm;

    // Only the low nibble of the immediate is a shift amount.
    assign unused_imm = ^immediate[WIDTH-1:4];

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .op       (ALUControl),
        .a        (RegSrc),
        .b        (RegDst),
        .k        (immediate[3:0]),
        .flags_in (status_q),
        .result   (ALUResult),
        .flags_out(newStatus)
    );

    always_comb begin
        status_d = newStatus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 4'b0000;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a behavioural flag model
module tb_execute_stage;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ALUControl;
    logic [15:0] RegSrc;
    logic [15:0] RegDst;
    logic [15:0] immediate;
    logic [3:0]  newStatus;
    logic [15:0] ALUResult;
    logic [3:0]  status;

    int          tests;
    int          fails;
    logic [3:0]  model_st;

    execute_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUControl(ALUControl),
        .RegSrc    (RegSrc),
        .RegDst    (RegDst),
        .immediate (immediate),
        .newStatus (newStatus),
        .ALUResult (ALUResult),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Returns {V,C,N,Z, result[15:0]} from plain integer arithmetic.
    function automatic logic [19:0] ref_alu(input logic [3:0] op, input int a, input int b,
                                            input int k, input logic [3:0] st);
        int   r;
        int   s;
        logic c;
        logic v;
        logic n;
        logic z;
        logic upd;
        c   = st[2];
        v   = st[3];
        r   = 0;
        upd = 1'b1;
        case (op)
            4'd0: begin
                r = a + b; c = (r > 65535);
                s = sx(a) + sx(b); v = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                r = b - a; c = (a > b);
                s = sx(b) - sx(a); v = (s > 32767) || (s < -32768);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: begin
                r = a;
                if (k != 0) begin r = a * (1 << k); c = ((a / (1 << (16 - k))) % 2) == 1; end
            end
            4'd5: begin
                r = a;
                if (k != 0) begin r = a / (1 << k); c = ((a / (1 << (k - 1))) % 2) == 1; end
            end
            4'd6: r = 65535 - a;
            4'd7: begin r = b; upd = 1'b0; end
            4'd8: begin r = a + 1; c = (a == 65535); v = (a == 32767); end
            4'd9: begin r = a - 1; c = (a == 0); v = (a == 32768); end
            4'd10: begin r = a; upd = 1'b0; end
            4'd11: begin r = a; c = 1'b1; upd = 1'b0; end
            4'd12: begin r = a; c = 1'b0; upd = 1'b0; end
            default: begin r = 0; upd = 1'b0; end
        endcase
        r = r & 32'hFFFF;
        n = upd ? (r >= 32768) : st[1];
        z = upd ? (r == 0) : st[0];
        return {v, c, n, z, r[15:0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one operation, checks combinational outputs, then the registered status after the edge.
    task automatic dir(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm, input logic [15:0] exp_res,
                       input logic [3:0] mask, input logic [3:0] val);
        logic [19:0] e;
        ALUControl = op; RegSrc = a; RegDst = b; immediate = imm;
        #1;
        e = ref_alu(op, int'(a), int'(b), int'(imm[3:0]), model_st);
        check({tag, "_res"}, ALUResult, exp_res);
        check({tag, "_model_res"}, ALUResult, e[15:0]);
        if (mask != 4'b0000) check({tag, "_flag"}, {12'h0, newStatus & mask}, {12'h0, val});
        check({tag, "_ns"}, {12'h0, newStatus}, {12'h0, e[19:16]});
        @(posedge clk);
        #1;
        model_st = e[19:16];
        check({tag, "_st"}, {12'h0, status}, {12'h0, model_st});
    endtask

    task automatic rnd_step(input int idx);
        logic [19:0] e;
        logic [15:0] a;
        logic [15:0] b;
        a = (($urandom % 4) == 0) ? 16'(($urandom % 2) ? 16'hFFFF - $urandom_range(0, 1) : $urandom_range(0, 1) + (($urandom % 2) ? 16'h7FFF : 0)) : 16'($urandom);
        b = (($urandom % 4) == 0) ? a : 16'($urandom);
        ALUControl = 4'($urandom);
        RegSrc     = a;
        RegDst     = b;
        immediate  = 16'($urandom);
        #1;
        e = ref_alu(ALUControl, int'(a), int'(b), int'(immediate[3:0]), model_st);
        if (ALUResult !== e[15:0] || newStatus !== e[19:16])
            $display("  rnd %0d op=%h a=%h b=%h k=%0d st=%b", idx, ALUControl, a, b, immediate[3:0], model_st);
        check("rnd_res", ALUResult, e[15:0]);
        check("rnd_ns", {12'h0, newStatus}, {12'h0, e[19:16]});
        @(posedge clk);
        #1;
        model_st = e[19:16];
        check("rnd_st", {12'h0, status}, {12'h0, model_st});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_st = 4'b0000;
        rst_n = 1'b0;
        ALUControl = 4'd0; RegSrc = 16'h0; RegDst = 16'h0; immediate = 16'h0;
        #12;
        check("reset_status", {12'h0, status}, 16'h0000);
        check("reset_ns", {12'h0, newStatus}, 16'h0001);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        dir("add_small",  4'b0000, 16'h0005, 16'h0006, 16'h0, 16'h000B, 4'b0100, 4'b0000);
        dir("add_ovf",    4'b0000, 16'h800F, 16'h800F, 16'h0, 16'h001E, 4'b1100, 4'b1100);
        dir("pass1",      4'b1010, 16'h0000, 16'h000F, 16'h0, 16'h0000, 4'b1111, 4'b1100);
        dir("pass2",      4'b0111, 16'h0000, 16'h000F, 16'h0, 16'h000F, 4'b1111, 4'b1100);
        dir("sub_pos",    4'b0001, 16'h0002, 16'h0005, 16'h0, 16'h0003, 4'b0001, 4'b0000);
        dir("sub_zero",   4'b0001, 16'h0005, 16'h0005, 16'h0, 16'h0000, 4'b0101, 4'b0001);
        dir("sub_neg",    4'b0001, 16'h0006, 16'h0005, 16'h0, 16'hFFFF, 4'b0110, 4'b0110);
        dir("and",        4'b0010, 16'h0005, 16'h0005, 16'h0, 16'h0005, 4'b0011, 4'b0000);
        dir("not",        4'b0110, 16'h000F, 16'h1234, 16'h0, 16'hFFF0, 4'b0010, 4'b0010);
        dir("shl_c0",     4'b0100, 16'h000F, 16'h0000, 16'h0002, 16'h003C, 4'b0100, 4'b0000);
        dir("shl_c1",     4'b0100, 16'hC00F, 16'h0000, 16'hFFF2, 16'h003C, 4'b0100, 4'b0100);
        dir("shr_c0",     4'b0101, 16'h01E0, 16'h0000, 16'h0002, 16'h0078, 4'b0100, 4'b0000);
        dir("shr_c1",     4'b0101, 16'h000F, 16'h0000, 16'h0002, 16'h0003, 4'b0100, 4'b0100);
        dir("shl_k0",     4'b0100, 16'h1234, 16'h0000, 16'h0010, 16'h1234, 4'b0100, 4'b0100);
        dir("clrc",       4'b1100, 16'h0007, 16'h0000, 16'h0, 16'h0007, 4'b0100, 4'b0000);
        dir("shr_k0",     4'b0101, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 4'b0110, 4'b0010);
        dir("inc_0",      4'b1000, 16'h0000, 16'h0000, 16'h0, 16'h0001, 4'b0001, 4'b0000);
        dir("dec_1",      4'b1001, 16'h0001, 16'h0000, 16'h0, 16'h0000, 4'b0001, 4'b0001);
        dir("inc_ffff",   4'b1000, 16'hFFFF, 16'h0000, 16'h0, 16'h0000, 4'b0101, 4'b0101);
        dir("dec_0",      4'b1001, 16'h0000, 16'h0000, 16'h0, 16'hFFFF, 4'b0100, 4'b0100);
        dir("inc_7fff",   4'b1000, 16'h7FFF, 16'h0000, 16'h0, 16'h8000, 4'b1000, 4'b1000);
        dir("dec_8000",   4'b1001, 16'h8000, 16'h0000, 16'h0, 16'h7FFF, 4'b1000, 4'b1000);
        dir("setc",       4'b1011, 16'h0000, 16'h0000, 16'h0, 16'h0000, 4'b0100, 4'b0100);
        dir("clrc2",      4'b1100, 16'hABCD, 16'h0000, 16'h0, 16'hABCD, 4'b0100, 4'b0000);
        dir("reserved",   4'b1101, 16'h0005, 16'h0007, 16'h0, 16'h0000, 4'b0000, 4'b0000);

        dir("add_ovf2",   4'b0000, 16'h800F, 16'h800F, 16'h0, 16'h001E, 4'b0100, 4'b0100);
        check("reg_c_set", {15'h0, status[2]}, 16'h0001);
        dir("pass1_hold", 4'b1010, 16'h0000, 16'h000F, 16'h0, 16'h0000, 4'b1111, 4'b1100);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset", {12'h0, status}, 16'h0000);
        model_st = 4'b0000;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            rnd_step(i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 16-bit RISC pipeline: a 16-bit ALU plus the architectural status (flag) register.
- Operands come from the decode/ID-EX latch: source register, destination register and immediate.
- The result and next-status go combinationally to the EX/MEM latch.
- The flag register updates on the clock so the following instruction sees the flags.

Parameters:
- WIDTH, 16, datapath width (all arithmetic below assumes 16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; clears the status register.
- ALUControl  in  4  operation select (encoding below).
- RegSrc  in  16  first operand (Rsrc).
- RegDst  in  16  second operand (Rdst value).
- immediate  in  16  shift amount source; only bits [3:0] are used.
- newStatus  out  4  combinational next flags {V,C,N,Z} = bits [3:0] {3:V, 2:C, 1:N, 0:Z}.
- ALUResult  out  16  combinational ALU result.
- status  out  4  registered flag register (current flags).

Behaviour:
- ALUResult and newStatus are purely combinational from inputs plus the `status` register; there is no latency.
- status <= newStatus on every rising clk.
- rst_n low: status = 4'b0000 immediately (async); it is released synchronously to operation on the next edge.
- Operation encoding (A=RegSrc, B=RegDst, k=immediate[3:0]):
  - 0000 ADD: B+A; C=carry out of bit15; V=signed overflow.
  - 0001 SUB: B−A; C=borrow (A>B unsigned); V=signed overflow.
  - 0010 AND: A&B; C,V held.
  - 0011 OR: A|B; C,V held.
  - 0100 SHL: A<<k; C=A[16−k] (last bit shifted out); k=0 → result A, C held; V held.
  - 0101 SHR: A>>k logical; C=A[k−1]; k=0 → result A, C held; V held.
  - 0110 NOT: ~A; C,V held.
  - 0111 PASS2: B; all flags held.
  - 1000 INC: A+1; C=carry out, V=overflow (0x7FFF→0x8000).
  - 1001 DEC: A−1; C=borrow (A==0), V=overflow (0x8000→0x7FFF).
  - 1010 PASS1: A; all flags held.
  - 1011 SETC: result A; C=1, others held.
  - 1100 CLRC: result A; C=0, others held.
  - 1101–1111 reserved: result 16'h0000; all flags held.
- Z=(result==0), N=result[15] for ADD/SUB/AND/OR/SHL/SHR/NOT/INC/DEC; otherwise held.
- "Held" means newStatus bit = current status bit.
- Wrap-around: ADD/INC/SUB/DEC are modulo 2^16.

Decomposition:
- Shared package holds:
  - the ALUControl opcode localparams (ALU_ADD … ALU_CLRC);
  - flag bit index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3).
- One natural sub-module: alu_core (combinational result + new flags from op, operands and current flags).
- execute_stage wraps alu_core and adds the status register.

Test Plan:
- ADD: A=5, B=6 → ALUResult=11, newStatus[2]=0. Then A=B=0x800F → ALUResult=0x001E, C=1, V=1.
- SUB: A=2, B=5 → 3, Z=0. Then A=B=5 → 0, Z=1, C=0. A=6, B=5 → 0xFFFF, N=1, C=1.
- Logic ops:
  - AND A=B=5 → 5.
  - NOT A=0x000F → 0xFFF0, N=1.
  - PASS1 A=0, B=0x000F → 0, flags equal status.
  - PASS2 same operands → 0x000F.
- Shifts:
  - SHL A=0x000F, k=2 → 0x003C, C=0.
  - SHL A=0xC00F, k=2 → 0x003C, C=1.
  - SHR A=0x01E0, k=2 → 0x0078, C=0.
  - SHR A=0x000F, k=2 → 0x0003, C=1.
  - k=0 → result A, C unchanged.
- INC/DEC:
  - INC A=0 → 1.
  - DEC A=1 → 0, Z=1.
  - INC A=0xFFFF → 0, C=1, Z=1.
  - DEC A=0 → 0xFFFF, C=1.
- Register/reset:
  - After ADD 0x800F+0x800F, a clk edge gives status[2]=1.
  - Then PASS1 keeps newStatus = status.
  - Asserting rst_n=0 mid-cycle → status=0 without a clock edge.
  - SETC/CLRC toggle status[2] on the next edge.
